// File: rtl/lane_unpacker.sv
// lane_unpacker
//   Two-slot lane buffer that turns whole input words into a sliding window of
//   lanes. Downstream sees up to NUM_DATA pending lanes, oldest at lane 0, and
//   takes any number of them per cycle via consume_i.
//
// Ports
//   clk_i           sole clock, rising edge
//   rst_i           synchronous active-high reset
//   input_vector_i  packed input word, lane 0 oldest
//   in_valid_i      input word present
//   in_ready_o      block can accept a word this cycle
//   output_vector_o pending lanes rotated so the oldest is at lane 0, zero-filled
//   out_count_o     number of valid lanes on output_vector_o (0..NUM_DATA)
//   consume_i       lanes taken by downstream this cycle (clamped to out_count_o)
//
// Handshake: a word transfers on a rising edge where in_valid_i && in_ready_o.
// in_ready_o depends only on registered state (S1 empty), never on in_valid_i
// or consume_i. Output side is credit-like: out_count_o lanes are offered and
// consume_i of them (clamped) are taken on the edge.
module lane_unpacker #(
  parameter int NUM_DATA   = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  input_vector_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  output_vector_o,
  output logic [$clog2(NUM_DATA):0]            out_count_o,
  input  logic [$clog2(NUM_DATA):0]            consume_i
);

  localparam int PW = $clog2(NUM_DATA);  // rd_ptr width
  localparam int CW = PW + 1;            // count width
  localparam int AW = CW + 1;            // avail width, holds up to 2*NUM_DATA

  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] s0_data, s1_data;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] s0_data_nxt, s1_data_nxt;
  logic                                s0_valid, s1_valid;
  logic                                s0_valid_nxt, s1_valid_nxt;
  logic [PW-1:0]                       rd_ptr, rd_ptr_nxt;

  logic [2*NUM_DATA-1:0][DATA_WIDTH-1:0] lanes_all;
  logic [AW-1:0]                         avail;
  logic [CW-1:0]                         eff;
  logic [CW-1:0]                         sum;
  logic                                  accept;
  logic                                  retire;

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only
  // ---------------------------------------------------------------------------
  assign in_ready_o = !s1_valid;
  assign lanes_all  = {s1_data, s0_data};

  always_comb begin
    avail = '0;
    if (s0_valid) avail = AW'(NUM_DATA) - AW'(rd_ptr);
    if (s1_valid) avail = avail + AW'(NUM_DATA);
  end

  assign out_count_o = (avail > AW'(NUM_DATA)) ? CW'(NUM_DATA) : avail[CW-1:0];

  // rd_ptr + k never exceeds 2*NUM_DATA-2, so a CW-bit index covers {S1,S0}.
  always_comb begin
    output_vector_o = '0;
    for (int k = 0; k < NUM_DATA; k++) begin
      if (CW'(k) < out_count_o)
        output_vector_o[k] = lanes_all[CW'(rd_ptr) + CW'(k)];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: retire decision first, then place the accepted word in the
  // first slot that is free afterwards.
  // ---------------------------------------------------------------------------
  assign accept = in_valid_i && !s1_valid;
  assign eff    = (consume_i > out_count_o) ? out_count_o : consume_i;
  assign sum    = CW'(rd_ptr) + eff;
  assign retire = (sum >= CW'(NUM_DATA));

  always_comb begin
    s0_data_nxt  = s0_data;
    s1_data_nxt  = s1_data;
    s0_valid_nxt = s0_valid;
    s1_valid_nxt = s1_valid;
    rd_ptr_nxt   = sum[PW-1:0];

    if (retire) begin
      s0_data_nxt  = s1_data;
      s0_valid_nxt = s1_valid;
      s1_valid_nxt = 1'b0;
      rd_ptr_nxt   = PW'(sum - CW'(NUM_DATA));
      // Retiring the last slot leaves the buffer empty; restart at lane 0.
      if (!s1_valid) rd_ptr_nxt = '0;
    end

    if (accept) begin
      if (!s0_valid_nxt) begin
        // Covers both an idle buffer and retire+accept with S1 empty, so the
        // new word shows up without a zero-count bubble.
        s0_data_nxt  = input_vector_i;
        s0_valid_nxt = 1'b1;
        rd_ptr_nxt   = '0;
      end else begin
        s1_data_nxt  = input_vector_i;
        s1_valid_nxt = 1'b1;
      end
    end
  end

  // Control state with reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      rd_ptr   <= '0;
    end else begin
      s0_valid <= s0_valid_nxt;
      s1_valid <= s1_valid_nxt;
      rd_ptr   <= rd_ptr_nxt;
    end
  end

  // Slot payloads are qualified by the valid flags, so they carry no reset.
  always_ff @(posedge clk_i) begin
    s0_data <= s0_data_nxt;
    s1_data <= s1_data_nxt;
  end

endmodule

// File: tb/tb_lane_unpacker.sv
module tb_lane_unpacker;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int CW = $clog2(N) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][DW-1:0] in_vec;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0][DW-1:0] out_vec;
  logic [CW-1:0]        out_count;
  logic [CW-1:0]        consume;

  lane_unpacker #(.NUM_DATA(N), .DATA_WIDTH(DW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .input_vector_i  (in_vec),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .output_vector_o (out_vec),
    .out_count_o     (out_count),
    .consume_i       (consume)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [CW-1:0] exp_cnt,
                           input logic [15:0] exp_vec, input logic exp_rdy);
    check({tag, ".count"}, 32'(out_count), 32'(exp_cnt));
    check({tag, ".vec"},   32'(out_vec),   32'(exp_vec));
    check({tag, ".ready"}, 32'(in_ready),  32'(exp_rdy));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, take one rising edge, sample #1 later
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [15:0] word, input logic [CW-1:0] c);
    in_valid = v;
    in_vec   = word;
    consume  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    consume  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0;
    in_vec   = '0;
    consume  = '0;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset", 3'd0, 16'h0000, 1'b1);

    // Push {0,1,2,3}, nothing consumed
    cycle(1'b1, 16'h3210, 3'd0);
    check_out("push0", 3'd4, 16'h3210, 1'b1);

    // Consume 3 -> one lane left (lane 3)
    cycle(1'b0, 16'hffff, 3'd3);
    check_out("cons3", 3'd1, 16'h0003, 1'b1);

    // Push {4,5,6,7} into S1, window straddles the slots
    cycle(1'b1, 16'h7654, 3'd0);
    check_out("push1", 3'd4, 16'h6543, 1'b0);

    // Consume 4 across the slot boundary -> lane 7 remains
    cycle(1'b0, 16'h0000, 3'd4);
    check_out("cons4", 3'd1, 16'h0007, 1'b1);

    // Drain the last lane -> empty
    cycle(1'b0, 16'h0000, 3'd1);
    check_out("drain", 3'd0, 16'h0000, 1'b1);

    // Two pushes with no consumption fill both slots
    cycle(1'b1, 16'h4321, 3'd0);
    check_out("fill_a", 3'd4, 16'h4321, 1'b1);
    cycle(1'b1, 16'h8765, 3'd0);
    check_out("fill_b", 3'd4, 16'h4321, 1'b0);

    // Third word offered while full is held off
    cycle(1'b1, 16'hcba9, 3'd0);
    check_out("held", 3'd4, 16'h4321, 1'b0);

    // Consume 4 while the third word is still offered; it is not accepted
    cycle(1'b1, 16'hcba9, 3'd4);
    check_out("unblock", 3'd4, 16'h8765, 1'b1);

    // Consume 2 -> count 2 (lanes 7,8)
    cycle(1'b0, 16'h0000, 3'd2);
    check_out("cons2", 3'd2, 16'h0087, 1'b1);

    // Consume 4 clamps to 2, simultaneous push, no empty bubble
    cycle(1'b1, 16'hba98, 3'd4);
    check_out("clamp", 3'd4, 16'hba98, 1'b1);

    // Push while consuming 1: rd_ptr 1, word goes to S1
    cycle(1'b1, 16'hfedc, 3'd1);
    check_out("mix1", 3'd4, 16'hcba9, 1'b0);

    // Consume 2 with no retire: rd_ptr 3
    cycle(1'b0, 16'h0000, 3'd2);
    check_out("mix2", 3'd4, 16'hedcb, 1'b0);

    // Reset with both slots full; valid and consume must be ignored
    rst = 1'b1;
    cycle(1'b1, 16'h1111, 3'd4);
    rst = 1'b0;
    check_out("midrst", 3'd0, 16'h0000, 1'b1);

    // Next push shows only new lanes
    cycle(1'b1, 16'h5a5a, 3'd0);
    check_out("postrst", 3'd4, 16'h5a5a, 1'b1);

    // Consume all -> no stale S1 lanes reappear
    cycle(1'b0, 16'h0000, 3'd4);
    check_out("nostale", 3'd0, 16'h0000, 1'b1);

    // Input contents ignored without in_valid
    cycle(1'b0, 16'hffff, 3'd0);
    check_out("novalid", 3'd0, 16'h0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/lane_unpacker.md
LANE_UNPACKER -- requirements
Module: lane_unpacker

Interface
REQ-001 SHALL have parameter NUM_DATA, default 4, number of lanes per word; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, width of each lane in bits.
REQ-003 SHALL have port clk_i, input, 1 bit, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have port input_vector_i, input, [NUM_DATA-1:0][DATA_WIDTH-1:0], packed word; lane 0 is the oldest.
REQ-006 SHALL have port in_valid_i, input, 1 bit, input word present.
REQ-007 SHALL have port in_ready_o, output, 1 bit, block can accept a word this cycle.
REQ-008 SHALL have port output_vector_o, output, [NUM_DATA-1:0][DATA_WIDTH-1:0], pending lanes rotated so the oldest pending lane is at lane 0.
REQ-009 SHALL have port out_count_o, output, $clog2(NUM_DATA)+1 bits, number of valid lanes on output_vector_o (0..NUM_DATA).
REQ-010 SHALL have port consume_i, input, $clog2(NUM_DATA)+1 bits, number of lanes the downstream takes this cycle.

Function
REQ-011 SHALL hold two word slots, S0 (current) and S1 (next), each with a valid flag, plus a read pointer rd_ptr of $clog2(NUM_DATA) bits indexing the next unread lane of S0.
REQ-012 SHALL compute avail = (S0 valid ? NUM_DATA-rd_ptr : 0) + (S1 valid ? NUM_DATA : 0).
REQ-013 SHALL drive out_count_o = min(avail, NUM_DATA).
REQ-014 SHALL drive output_vector_o[k] = lane (rd_ptr+k) of the concatenation {S1,S0} (S0 lanes 0..N-1, S1 lanes N..2N-1) for k < out_count_o, and all-zero for k >= out_count_o.
REQ-015 SHALL make all outputs combinational functions of registered state only; no input-to-output combinational path.
REQ-016 SHALL drive in_ready_o = !S1.valid, independent of consume_i.
REQ-017 SHALL accept a word when in_valid_i && in_ready_o; the word is visible on the outputs the next cycle (latency 1).
REQ-018 SHALL clamp the effective consumption: eff = min(consume_i, out_count_o); eff = 0 leaves rd_ptr and slots unchanged.
REQ-019 SHALL compute sum = rd_ptr + eff (width $clog2(NUM_DATA)+1); sum < 2*NUM_DATA always holds, so at most one slot retires per cycle.
REQ-020 SHALL, when sum >= NUM_DATA (retire): move S1 into S0 with its valid flag, clear S1.valid, and set rd_ptr = sum - NUM_DATA.
REQ-021 SHALL, when sum < NUM_DATA: set rd_ptr = sum and keep both slots.
REQ-022 SHALL place an accepted word into the first slot that is free after the retire decision: into S0 if S0 is empty after retirement (rd_ptr forced to 0 when S0 was previously empty), otherwise into S1.
REQ-023 SHALL, when S0 retires with S1 invalid and no word is accepted, clear S0.valid and set rd_ptr to 0.
REQ-024 SHALL, for simultaneous accept and retire with S1 invalid, load the new word into S0 with rd_ptr = 0, so no cycle with out_count_o = 0 is inserted.
REQ-025 SHALL preserve lane order exactly: the lane sequence observed downstream equals the input lanes in order, with no loss or duplication.
REQ-026 SHALL ignore input_vector_i contents when the word is not accepted.

Reset
REQ-027 SHALL, while rst_i is high at a clock edge, clear S0.valid, S1.valid and rd_ptr, and ignore in_valid_i and consume_i.
REQ-028 SHALL present out_count_o = 0, output_vector_o = 0 and in_ready_o = 1 in the cycle after reset.
REQ-029 SHALL discard all buffered lanes on reset asserted mid-operation; slot data registers need no reset.

Verification (NUM_DATA=4, DATA_WIDTH=4)
REQ-030 SHALL cover: reset, push lanes {0,1,2,3}, consume 0 -> next cycle out_count 4, output {0,1,2,3}, in_ready 1.
REQ-031 SHALL cover: state from REQ-030, consume 3 -> rd_ptr 3, out_count 1, output {3,0,0,0}.
REQ-032 SHALL cover: state from REQ-031, push {4,5,6,7} -> out_count 4, output {3,4,5,6}; then consume 4 -> out_count 1, output {7,0,0,0}, in_ready 1.
REQ-033 SHALL cover: two pushes with no consumption -> in_ready 0, third word held off; consume 4 -> in_ready 1 next cycle.
REQ-034 SHALL cover: consume 4 while out_count is 2, with a simultaneous push of {8,9,A,B} -> exactly 2 lanes consumed, next output {8,9,A,B}, count 4.
REQ-035 SHALL cover: rst_i asserted with both slots full -> next cycle out_count 0, in_ready 1, no stale lanes after the next push.
